// File: rtl/lstm_out_err_buf_pkg.sv
// rtl/lstm_out_err_buf_pkg.sv - fixed-point constants, FSM encoding and saturation helper
package lstm_out_err_buf_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  localparam logic signed [2*WIDTH:0] WIDE_MAX = $signed({{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [2*WIDTH:0] WIDE_MIN = $signed({{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}});

  // Clamp a wide signed intermediate into the WIDTH-bit signed range.
  function automatic logic [WIDTH-1:0] sat_s(input logic signed [2*WIDTH:0] v);
    logic [WIDTH-1:0] r;
    if (v > WIDE_MAX)      r = POS_MAX;
    else if (v < WIDE_MIN) r = NEG_MIN;
    else                   r = v[WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/lstm_err_fifo.sv
// rtl/lstm_err_fifo.sv - first-word fall-through register FIFO for {addr, err} entries
module lstm_err_fifo #(
  parameter int DW    = 44,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // When empty, keep presenting the entry that was popped last.
  assign head = empty ? mem[rd_ptr - PW'(1)] : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lstm_out_err_buf.sv
// rtl/lstm_out_err_buf.sv - h2 output error, squared-error cost and dOut FIFO
module lstm_out_err_buf #(
  parameter int WIDTH      = lstm_out_err_buf_pkg::WIDTH,
  parameter int FRAC       = lstm_out_err_buf_pkg::FRAC,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CELL   = 8,
  parameter int TIMESTEP   = 7,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_h,
  input  logic [WIDTH-1:0]      in_t,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_err,
  output logic [ADDR_WIDTH-1:0] out_addr,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      cost,
  output logic                  cost_valid
);

  import lstm_out_err_buf_pkg::*;

  localparam int CW = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
  localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;

  state_t                     state;
  logic [CW-1:0]              cell_cnt;
  logic [TW-1:0]              ts_cnt;
  logic                       accept;
  logic                       last;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [ADDR_WIDTH+WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0]      addr;
  logic signed [2*WIDTH:0]    diff_w;
  logic [WIDTH-1:0]           err;
  logic signed [2*WIDTH-1:0]  err_w;
  logic signed [2*WIDTH-1:0]  sq_full;
  logic signed [2*WIDTH-1:0]  sq_sh;
  logic [WIDTH-1:0]           sq;
  logic signed [2*WIDTH:0]    sum_w;
  logic [WIDTH-1:0]           cost_next;

  assign in_ready  = (state == ST_RUN) & ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign last      = (cell_cnt == CW'(NUM_CELL-1)) && (ts_cnt == TW'(TIMESTEP-1));
  assign addr      = ADDR_WIDTH'(ts_cnt) * ADDR_WIDTH'(NUM_CELL) + ADDR_WIDTH'(cell_cnt);
  assign out_valid = ~fifo_empty;
  assign out_err   = head[WIDTH-1:0];
  assign out_addr  = head[ADDR_WIDTH+WIDTH-1:WIDTH];

  // Error and cost are evaluated with headroom, then clamped back to WIDTH bits.
  always_comb begin
    diff_w    = $signed({{(WIDTH+1){in_h[WIDTH-1]}}, in_h})
              - $signed({{(WIDTH+1){in_t[WIDTH-1]}}, in_t});
    err       = sat_s(diff_w);
    err_w     = $signed({{WIDTH{err[WIDTH-1]}}, err});
    sq_full   = err_w * err_w;
    sq_sh     = sq_full >>> FRAC;
    sq        = sat_s($signed({1'b0, sq_sh}));
    sum_w     = $signed({{(WIDTH+1){1'b0}}, cost}) + $signed({{(WIDTH+1){1'b0}}, sq});
    cost_next = sat_s(sum_w);
  end

  lstm_err_fifo #(
    .DW    (ADDR_WIDTH + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ({addr, err}),
    .pop       (out_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cell_cnt   <= '0;
      ts_cnt     <= '0;
      cost       <= '0;
      cost_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            cell_cnt   <= '0;
            ts_cnt     <= '0;
            cost       <= '0;
            cost_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cost <= cost_next;
            if (last) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              cost_valid <= 1'b1;
              busy       <= 1'b0;
              cell_cnt   <= '0;
              ts_cnt     <= '0;
            end else if (cell_cnt == CW'(NUM_CELL-1)) begin
              cell_cnt <= '0;
              ts_cnt   <= ts_cnt + TW'(1);
            end else begin
              cell_cnt <= cell_cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lstm_out_err_buf.md
Name: lstm_out_err_buf

Overview:
- Downstream consumer of the layer-2 LSTM output stream h2.
- Per sample: pairs each h2 value with its target, forms the output error dOut = h2 - t, and accumulates the squared-error cost.
- Buffers {address, error} pairs in a small FIFO with a valid/ready interface. The backprop layer-2 dOut memory writer drains this FIFO.

Parameters:
- WIDTH, 32, data width; signed fixed point.
- FRAC, 24, fraction bits (1.0 = 0x01000000).
- ADDR_WIDTH, 12, dOut memory address width.
- NUM_CELL, 8, layer-2 cells per timestep.
- TIMESTEP, 7, timesteps per sequence.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a sequence.
- in_valid  in  1  h2/target pair present.
- in_h  in  WIDTH  h2 sample, signed.
- in_t  in  WIDTH  target sample, signed.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- out_valid  out  1  FIFO head valid.
- out_err  out  WIDTH  head error value.
- out_addr  out  ADDR_WIDTH  head dOut address.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last sample of a sequence is accepted.
- cost  out  WIDTH  accumulated squared-error cost.
- cost_valid  out  1  cost final; held until the next start.

Behaviour:
- Reset (rst=0, async) clears:
  - state to IDLE;
  - counters, FIFO pointers and count;
  - cost, cost_valid, done, busy, out_valid to 0;
  - out_err and out_addr to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN: clear cell_cnt, ts_cnt, cost and cost_valid.
  - RUN --accept of sample NUM_CELL*TIMESTEP-1--> DONE: done=1 for exactly that following cycle; cost_valid=1.
  - DONE --start--> RUN: same clears as from IDLE.
  - start while in RUN is ignored.
- Handshake:
  - in_ready = (state==RUN) & (fifo_count<DEPTH).
  - A full FIFO deasserts in_ready even if a pop occurs in the same cycle (no pass-through).
- Address generation:
  - out_addr = ts_cnt*NUM_CELL + cell_cnt, captured at accept.
  - cell_cnt wraps NUM_CELL-1 -> 0 and increments ts_cnt.
  - Order is timestep-major, cell-minor: addresses 0 .. NUM_CELL*TIMESTEP-1.
- Error computation:
  - diff = in_h - in_t in WIDTH+1 bits.
  - err saturates to [0x8000_0000, 0x7FFF_FFFF] for WIDTH=32.
- Cost computation:
  - sq = (err*err) in 2*WIDTH bits, arithmetic shift right FRAC, clamped to 2^(WIDTH-1)-1.
  - cost += sq, saturating at 2^(WIDTH-1)-1.
  - Registered in the accept cycle; cost is final in the same cycle done pulses.
- FIFO:
  - Register array, first-word fall-through.
  - Write registered at accept; out_valid rises the cycle after the first accept into an empty FIFO (latency 1).
  - Simultaneous push and pop when non-full and non-empty: count unchanged, both pointers advance.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - A start in DONE does not flush FIFO contents.
- out_err and out_addr are driven from the head entry; they are don't-care-free and show the last head value when empty.
- Reset mid-RUN: everything returns to reset values immediately; pending FIFO data is lost.

Decomposition:
- Shared package holds:
  - fixed-point constants (WIDTH, FRAC, POS_MAX, NEG_MIN);
  - the FSM state encoding localparams;
  - a saturation helper function used for both err and cost.
- One natural sub-module: lstm_err_fifo (DEPTH x (ADDR_WIDTH+WIDTH) FWFT FIFO with count, full, empty). FSM, counters and arithmetic remain in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0, in_ready=0.
- Basic error:
  - Stimulus: start, then in_h=0x01800000, in_t=0x01000000.
  - Response: out_err=0x00800000, out_addr=0, out_valid one cycle after accept; cost=0x00400000.
- Saturation:
  - Stimulus: in_h=0x7FFFFFFF, in_t=0x80000000.
  - Response: out_err=0x7FFFFFFF; cost=0x7FFFFFFF and stays there on further nonzero samples.
- Full sequence:
  - Stimulus: NUM_CELL=2, TIMESTEP=3, out_ready=1, six back-to-back samples.
  - Response: out_addr 0,1,2,3,4,5; done pulses once after the 6th accept; busy and in_ready drop; cost_valid=1.
- Backpressure:
  - Stimulus: DEPTH=4, out_ready=0, five samples offered.
  - Response: four accepted, in_ready=0, fifth held; one pop gives in_ready=1 next cycle.
- Reset and restart:
  - Stimulus: assert rst low after 3 accepts.
  - Response: out_valid=0 immediately and cost=0; a subsequent start restarts addresses at 0.
- start mid-RUN is ignored (counters continue).
